// File: rtl/x25519_ladder_engine.sv
// Montgomery-ladder sequencer for X25519 k*u returning projective (X,Z); inversion happens downstream.
// Optional X25519_LADDER_CLAMP_EN: clamp the latched scalar; undefined uses the scalar verbatim.

module x25519_ladder_core (
  input  logic         clk,
  input  logic         en,
  input  logic         b,
  input  logic [511:0] xzm,
  input  logic [511:0] xzm1,
  input  logic [263:0] work_low,
  output logic         out_valid,
  output logic [511:0] xzm_out,
  output logic [511:0] xzm1_out
);
  localparam logic [255:0] P   = {1'b0, {250{1'b1}}, 5'b01101};
  localparam logic [255:0] A24 = 256'd121665;

  // Full reduction mod 2^255-19: fold 2^256 == 38 twice, then 2^255 == 19, then one conditional subtract.
  function automatic logic [255:0] fred(input logic [511:0] v);
    logic [262:0] t1;
    logic [256:0] t2;
    logic [255:0] t3;
    t1 = 263'(v[255:0]) + 263'(v[511:256]) * 263'(38);
    t2 = 257'(t1[255:0]) + 257'(t1[262:256]) * 257'(38);
    t3 = 256'(t2[254:0]) + 256'(t2[256:255]) * 256'(19);
    return (t3 >= P) ? t3 - P : t3;
  endfunction

  function automatic logic [255:0] fadd(input logic [255:0] a, input logic [255:0] c);
    logic [256:0] s;
    s = 257'(a) + 257'(c);
    if (s >= 257'(P)) s = s - 257'(P);
    return 256'(s);
  endfunction

  function automatic logic [255:0] fsub(input logic [255:0] a, input logic [255:0] c);
    return (a >= c) ? a - c : a - c + P;
  endfunction

  function automatic logic [255:0] fmul(input logic [255:0] a, input logic [255:0] c);
    return fred(512'(a) * 512'(c));
  endfunction

  logic         v0, v1;
  logic [255:0] x2_q, z2_q, x3_q, z3_q, u0_q, u1_q, aa_q, bb_q, da_q, cb_q;
  logic [255:0] a_c, b_c, c_c, d_c, e_c, s_c, t_c, nx2_c, nz2_c, nx3_c, nz3_c;
  logic [511:0] sel0_c, sel1_c;

  // Entry swap on b so the datapath always doubles the first operand.
  always_comb begin
    sel0_c = b ? xzm1 : xzm;
    sel1_c = b ? xzm : xzm1;
  end

  always_ff @(posedge clk) begin : stage0
    v0 <= en;
    if (en) begin
      x2_q <= fred(512'(sel0_c[255:0]));
      z2_q <= fred(512'(sel0_c[511:256]));
      x3_q <= fred(512'(sel1_c[255:0]));
      z3_q <= fred(512'(sel1_c[511:256]));
      u0_q <= fred(512'(work_low));
    end
  end

  always_comb begin
    a_c = fadd(x2_q, z2_q);
    b_c = fsub(x2_q, z2_q);
    c_c = fadd(x3_q, z3_q);
    d_c = fsub(x3_q, z3_q);
  end

  always_ff @(posedge clk) begin : stage1
    v1 <= v0;
    if (v0) begin
      aa_q <= fmul(a_c, a_c);
      bb_q <= fmul(b_c, b_c);
      da_q <= fmul(d_c, a_c);
      cb_q <= fmul(c_c, b_c);
      u1_q <= u0_q;
    end
  end

  always_comb begin
    e_c   = fsub(aa_q, bb_q);
    s_c   = fadd(da_q, cb_q);
    t_c   = fsub(da_q, cb_q);
    nx3_c = fmul(s_c, s_c);
    nz3_c = fmul(u1_q, fmul(t_c, t_c));
    nx2_c = fmul(aa_q, bb_q);
    nz2_c = fmul(e_c, fadd(aa_q, fmul(A24, e_c)));
  end

  // Exit swap undoes the entry swap; b is held stable by the sequencer.
  always_ff @(posedge clk) begin : stage2
    out_valid <= v1;
    if (v1) begin
      xzm_out  <= b ? {nz3_c, nx3_c} : {nz2_c, nx2_c};
      xzm1_out <= b ? {nz2_c, nx2_c} : {nz3_c, nx3_c};
    end
  end
endmodule

module x25519_ladder_engine #(
  parameter int unsigned SCALAR_WIDTH = 256,
  parameter int unsigned TOP_BIT      = 254
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [SCALAR_WIDTH-1:0] scalar,
  input  logic [255:0]            u_in,
  output logic                    ready,
  output logic                    busy,
  output logic                    done,
  output logic [255:0]            x_out,
  output logic [255:0]            z_out,
  output logic [7:0]              iter_idx
);
  localparam logic [7:0] TOP_IDX = 8'(TOP_BIT);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_FLUSH} state_t;

  state_t                  state, state_d;
  logic [SCALAR_WIDTH-1:0] k_lat, k_acc_c;
  logic [255:0]            u_lat;
  logic [511:0]            xzm, xzm1, core_xzm, core_xzm1;
  logic                    core_en, core_b, core_valid, accept_c;
  logic                    inflight, inflight_c, inflight_rst_c;

  if (TOP_BIT >= SCALAR_WIDTH || TOP_BIT > 255) begin : g_bad_top
    $error("TOP_BIT must lie within the scalar and below 256");
  end

`ifdef X25519_LADDER_CLAMP_EN
  if (SCALAR_WIDTH != 256) begin : g_bad_clamp
    $error("X25519_LADDER_CLAMP_EN requires SCALAR_WIDTH=256");
  end
  always_comb begin
    k_acc_c                 = scalar;
    k_acc_c[2:0]            = 3'b000;
    k_acc_c[SCALAR_WIDTH-1] = 1'b0;
    k_acc_c[SCALAR_WIDTH-2] = 1'b1;
  end
`else
  assign k_acc_c = scalar;
`endif

  // An iteration issued before reset still completes in the core, so reset may land in FLUSH.
  always_ff @(posedge clk) begin : state_reg
    if (rst) state <= inflight_rst_c ? S_FLUSH : S_IDLE;
    else     state <= state_d;
  end

  always_comb begin : next_state
    state_d = state;
    unique case (state)
      S_IDLE:  if (accept_c) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (core_valid) state_d = (iter_idx == 8'd0) ? S_DONE : S_ISSUE;
      S_DONE:  state_d = S_IDLE;
      S_FLUSH: if (core_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin : outputs_comb
    core_en        = 1'b0;
    accept_c       = 1'b0;
    core_en        = (state == S_ISSUE);
    accept_c       = (state == S_IDLE) && start && ready;
    inflight_c     = core_en || (inflight && !core_valid);
    inflight_rst_c = core_en || ((state == S_WAIT || state == S_FLUSH) && inflight && !core_valid);
  end

  assign core_b = k_lat[iter_idx];

  always_ff @(posedge clk) begin : ctrl_reg
    if (rst) begin
      inflight <= inflight_rst_c;
      ready    <= !inflight_rst_c;
      busy     <= inflight_rst_c;
      done     <= 1'b0;
      x_out    <= '0;
      z_out    <= '0;
      iter_idx <= TOP_IDX;
    end else begin
      inflight <= inflight_c;
      ready    <= (state_d == S_IDLE) && (state != S_DONE);
      busy     <= (state_d != S_IDLE);
      done     <= (state == S_DONE);
      if (state == S_DONE) begin
        x_out <= xzm[255:0];
        z_out <= xzm[511:256];
      end
      if (accept_c || state == S_DONE) iter_idx <= TOP_IDX;
      else if (state == S_WAIT && core_valid && iter_idx != 8'd0) iter_idx <= iter_idx - 8'd1;
    end
  end

  // Ladder state starts at (1:0) and (u:1), packed {Z,X}.
  always_ff @(posedge clk) begin : data_reg
    if (!rst && accept_c) begin
      k_lat <= k_acc_c;
      u_lat <= u_in;
      xzm   <= {256'd0, 256'd1};
      xzm1  <= {256'd1, u_in};
    end else if (state == S_WAIT && core_valid) begin
      xzm  <= core_xzm;
      xzm1 <= core_xzm1;
    end
  end

  x25519_ladder_core u_core (
    .clk       (clk),
    .en        (core_en),
    .b         (core_b),
    .xzm       (xzm),
    .xzm1      (xzm1),
    .work_low  ({8'h00, u_lat}),
    .out_valid (core_valid),
    .xzm_out   (core_xzm),
    .xzm1_out  (core_xzm1)
  );
endmodule

// File: tb/tb_x25519_ladder_engine.sv
// Bench for x25519_ladder_engine: RFC 7748 vector, corner scalars, reset abort, held start, random ladders.
module tb_x25519_ladder_engine;
  localparam int unsigned L_ITER = 3;
  localparam int unsigned TOP_B  = 254;
  localparam int unsigned TOP_S  = 3;
  localparam int LAT_B = (TOP_B + 1) * (1 + L_ITER) + 2;
  localparam int LAT_S = (TOP_S + 1) * (1 + L_ITER) + 2;
  localparam logic [511:0] P = (512'd1 << 255) - 512'd19;
  localparam logic [255:0] V1K = 256'ha546e36bf0527c9d3b16154b82465edd62144c0ac1fc5a18506a2244ba449ac4;
  localparam logic [255:0] V1U = 256'he6db6867583030db3594c1a424b15f7c726624ec26b3353b10a903a6d0ab1c4c;
  localparam logic [255:0] V1O = 256'hc3da55379de9c6908e94ea4df28d084f32eccf03491c71f754b4075577a28552;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, start_s;
  logic [255:0] scalar, scalar_s, u_in, u_s;
  logic         ready, busy, done, ready_s, busy_s, done_s;
  logic [255:0] x_out, z_out, x_out_s, z_out_s;
  logic [7:0]   iter_idx, iter_idx_s;

  int n_checks = 0;
  int n_pass   = 0;

  x25519_ladder_engine #(.SCALAR_WIDTH(256), .TOP_BIT(TOP_B)) dut (
    .clk(clk), .rst(rst), .start(start), .scalar(scalar), .u_in(u_in),
    .ready(ready), .busy(busy), .done(done), .x_out(x_out), .z_out(z_out), .iter_idx(iter_idx));

  x25519_ladder_engine #(.SCALAR_WIDTH(256), .TOP_BIT(TOP_S)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .scalar(scalar_s), .u_in(u_s),
    .ready(ready_s), .busy(busy_s), .done(done_s), .x_out(x_out_s), .z_out(z_out_s), .iter_idx(iter_idx_s));

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] mm(input logic [511:0] a, input logic [511:0] c);
    return (a * c) % P;
  endfunction

  function automatic logic [511:0] inv(input logic [511:0] z);
    logic [511:0] r, base, e;
    r = 512'd1; base = z % P; e = P - 512'd2;
    for (int i = 0; i < 256; i++) begin
      if (e[i]) r = mm(r, base);
      base = mm(base, base);
    end
    return r;
  endfunction

  function automatic logic [255:0] le(input logic [255:0] s);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = s[8*(31-i) +: 8];
    return r;
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  // Reference ladder with the cumulative conditional-swap formulation.
  task automatic ladder_ref(input logic [255:0] k, input logic [255:0] u, input int top,
                            output logic [255:0] rx, output logic [255:0] rz);
    logic [511:0] x1, x2, z2, x3, z3, t, a, aa, b, bb, e, c, d, da, cb;
    logic sw, kt;
    x1 = 512'(u) % P; x2 = 512'd1; z2 = 512'd0; x3 = x1; z3 = 512'd1; sw = 1'b0;
    for (int i = top; i >= 0; i--) begin
      kt = k[i];
      sw = sw ^ kt;
      if (sw) begin t = x2; x2 = x3; x3 = t; t = z2; z2 = z3; z3 = t; end
      sw = kt;
      a  = (x2 + z2) % P;      aa = mm(a, a);
      b  = (x2 + P - z2) % P;  bb = mm(b, b);
      e  = (aa + P - bb) % P;
      c  = (x3 + z3) % P;      d  = (x3 + P - z3) % P;
      da = mm(d, a);           cb = mm(c, b);
      x3 = mm((da + cb) % P, (da + cb) % P);
      z3 = mm(x1, mm((da + P - cb) % P, (da + P - cb) % P));
      x2 = mm(aa, bb);
      z2 = mm(e, (aa + mm(512'd121665, e)) % P);
    end
    if (sw) begin t = x2; x2 = x3; x3 = t; t = z2; z2 = z3; z3 = t; end
    rx = 256'(x2); rz = 256'(z2);
  endtask

  // One ladder on the selected instance; cyc counts cycles from the accepting edge to done.
  task automatic run(input bit sm, input logic [255:0] k, input logic [255:0] u,
                     output logic [255:0] x, output logic [255:0] z,
                     output int cyc, output int ens, output logic dn_after);
    int guard;
    guard = 0;
    while (!(sm ? ready_s : ready) && guard < 3000) begin step(); guard++; end
    if (sm) begin start_s = 1'b1; scalar_s = k; u_s = u; end
    else    begin start   = 1'b1; scalar   = k; u_in = u; end
    step();
    start = 1'b0; start_s = 1'b0;
    cyc = 1; ens = 0;
    while (!(sm ? done_s : done) && cyc < 3000) begin
      if (sm ? dut_s.core_en : dut.core_en) ens++;
      step();
      cyc++;
    end
    x = sm ? x_out_s : x_out;
    z = sm ? z_out_s : z_out;
    step();
    dn_after = sm ? done_s : done;
  endtask

  initial begin
    logic [255:0] k, u, x, z, rx, rz;
    int cyc, cyc1, ens, guard, ndone;
    logic dn, stable, saw_done;
    logic [255:0] xref;

    rst = 1'b1; start = 1'b0; start_s = 1'b0;
    scalar = '0; scalar_s = '0; u_in = '0; u_s = '0;
    repeat (3) step();
    rst = 1'b0;
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_x", x_out, 0);
    check("rst_z", z_out, 0);
    check("rst_idx", iter_idx, TOP_B);
    check("rst_idx_s", iter_idx_s, TOP_S);

    // RFC 7748 vector 1, scalar clamped by the caller
    k = le(V1K); k[2:0] = 3'b000; k[255] = 1'b0; k[254] = 1'b1;
    u = le(V1U);
    run(1'b0, k, u, x, z, cyc, ens, dn);
    ladder_ref(k, u, TOP_B, rx, rz);
    check("v1_x", x, rx);
    check("v1_z", z, rz);
    check("v1_affine", mm(x, inv(z)), le(V1O));
    check("v1_latency", cyc, LAT_B);
    check("v1_en_pulses", ens, TOP_B + 1);
    check("v1_done_one_cycle", dn, 0);
    check("v1_idle_idx", iter_idx, TOP_B);

    // k=1 leaves u unchanged
    run(1'b0, 256'd1, 256'd9, x, z, cyc1, ens, dn);
    ladder_ref(256'd1, 256'd9, TOP_B, rx, rz);
    check("k1_x", x, rx);
    check("k1_affine", mm(x, inv(z)), 9);
    check("k1_en_pulses", ens, TOP_B + 1);
    check("k1_latency", cyc1, LAT_B);

    // k=0 yields the point at infinity in the same time
    u = rand256();
    run(1'b0, 256'd0, u, x, z, cyc, ens, dn);
    check("k0_z_zero", z, 0);
    check("k0_x_nonzero", x != 256'd0, 1);
    check("k0_same_time", cyc, cyc1);
    check("k0_en_pulses", ens, TOP_B + 1);

    // Reset while the iteration for bit 100 is issued
    start = 1'b1; scalar = rand256(); u_in = rand256();
    step();
    start = 1'b0;
    guard = 0;
    while (iter_idx != 8'd100 && guard < 2000) begin step(); guard++; end
    check("abort_reach_idx", iter_idx, 100);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("flush_busy", busy, 1);
    check("flush_ready", ready, 0);
    guard = 0; saw_done = 1'b0;
    while (!ready && guard < 100) begin
      if (done) saw_done = 1'b1;
      step(); guard++;
    end
    check("flush_ready_back", ready, 1);
    check("flush_busy_clear", busy, 0);
    check("flush_no_done", saw_done, 0);
    k = le(V1K); k[2:0] = 3'b000; k[255] = 1'b0; k[254] = 1'b1;
    u = le(V1U);
    run(1'b0, k, u, x, z, cyc, ens, dn);
    check("post_abort_affine", mm(x, inv(z)), le(V1O));
    check("post_abort_latency", cyc, LAT_B);

    // Short ladder: fixed example then random scalars and points
    run(1'b1, 256'b1011, 256'd9, x, z, cyc, ens, dn);
    ladder_ref(256'b1011, 256'd9, TOP_S, rx, rz);
    check("top3_x", x, rx);
    check("top3_z", z, rz);
    check("top3_en_pulses", ens, TOP_S + 1);
    check("top3_latency", cyc, LAT_S);
    for (int r = 0; r < 8; r++) begin
      k = rand256(); u = rand256();
      run(1'b1, k, u, x, z, cyc, ens, dn);
      ladder_ref(k, u, TOP_S, rx, rz);
      check("rand_x", x, rx);
      check("rand_z", z, rz);
      check("rand_latency", cyc, LAT_S);
    end

    // start held high: one ladder per idle entry, outputs stable between done pulses
    guard = 0;
    while (!ready_s && guard < 100) begin step(); guard++; end
    k = rand256(); u = rand256();
    ladder_ref(k, u, TOP_S, rx, rz);
    start_s = 1'b1; scalar_s = k; u_s = u;
    ndone = 0; ens = 0; stable = 1'b1; xref = '0; guard = 0;
    while (ndone < 3 && guard < 300) begin
      step(); guard++;
      if (dut_s.core_en) ens++;
      if (done_s) begin
        ndone++;
        check("held_en_per_run", ens, TOP_S + 1);
        check("held_x", x_out_s, rx);
        if (ndone > 1) check("held_x_stable", stable, 1);
        ens = 0; stable = 1'b1; xref = x_out_s;
      end else if (ndone > 0 && x_out_s != xref) begin
        stable = 1'b0;
      end
    end
    start_s = 1'b0;
    check("held_runs", ndone, 3);

    repeat (4) step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
